// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and buffered load returns into one
// registered register-file write stream. Optional: REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_alu_valid,
    output logic        alu_ready,
    input  logic [7:0]  tick_alu_waddr,
    input  logic [31:0] tick_alu_wdata,
    input  logic        tick_load_valid,
    output logic        load_ready,
    input  logic [7:0]  tick_load_waddr,
    input  logic [31:0] tick_load_word,
    input  logic [2:0]  tick_load_funct3,
    input  logic [1:0]  tick_load_offset,
    output logic [7:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_wren
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef struct packed {
        logic [7:0]  waddr;
        logic [31:0] word;
        logic [2:0]  funct3;
        logic [1:0]  offset;
    } load_entry_t;

    load_entry_t fifo_q [FIFO_DEPTH];
    load_entry_t fifo_d [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;

    logic [7:0]  wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        wb_wren_q, wb_wren_d;

    logic        fifo_empty;
    logic        alu_fire;
    logic        load_fire;
    logic        deq;
    logic        enq;
    logic        bypass;
    load_entry_t head;
    load_entry_t in_entry;

    // Extract byte/half from the aligned word and extend per RV32 funct3.
    function automatic logic [31:0] format_load(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  offset
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'h0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign load_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign alu_ready  = (starve_q != STV_W'(STARVE_LIMIT));
    assign alu_fire   = tick_alu_valid && alu_ready;
    assign load_fire  = tick_load_valid && load_ready;
    assign deq        = !alu_fire && !fifo_empty;

`ifdef REGFILE_WB_BYPASS_EN
    // An idle slot with an empty FIFO lets the incoming load skip the buffer.
    assign bypass = fifo_empty && !alu_fire && load_fire;
`else
    assign bypass = 1'b0;
`endif

    assign enq  = load_fire && !bypass;
    assign head = fifo_q[rd_ptr_q];

    assign in_entry = {tick_load_waddr, tick_load_word,
                       tick_load_funct3, tick_load_offset};

    // Write-slot arbitration: ALU first, then FIFO head, then bypassed load.
    always_comb begin
        logic sel_valid;
        sel_valid  = 1'b0;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        if (alu_fire) begin
            sel_valid  = 1'b1;
            wb_waddr_d = tick_alu_waddr;
            wb_wdata_d = tick_alu_wdata;
        end else if (deq) begin
            sel_valid  = 1'b1;
            wb_waddr_d = head.waddr;
            wb_wdata_d = format_load(head.word, head.funct3, head.offset);
        end else if (bypass) begin
            sel_valid  = 1'b1;
            wb_waddr_d = in_entry.waddr;
            wb_wdata_d = format_load(in_entry.word, in_entry.funct3,
                                     in_entry.offset);
        end
        wb_wren_d = sel_valid && (wb_waddr_d[4:0] != 5'd0);
    end

    // Load FIFO storage, pointers and occupancy.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            fifo_d[wr_ptr_q] = in_entry;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Count how long a waiting head has been passed over by ALU traffic.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || deq) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // State registers; reset drops queued loads and any pending write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
            wb_wren_q  <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            wb_wren_q  <= wb_wren_d;
        end
    end

    assign wb_waddr = wb_waddr_q;
    assign wb_wdata = wb_wdata_q;
    assign wb_wren  = wb_wren_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed checks of arbitration, load formatting,
// x0 suppression, starvation bound and reset flush.
module tb_regfile_writeback;

    logic        clock;
    logic        reset;
    logic        tick_alu_valid;
    logic        alu_ready;
    logic [7:0]  tick_alu_waddr;
    logic [31:0] tick_alu_wdata;
    logic        tick_load_valid;
    logic        load_ready;
    logic [7:0]  tick_load_waddr;
    logic [31:0] tick_load_word;
    logic [2:0]  tick_load_funct3;
    logic [1:0]  tick_load_offset;
    logic [7:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_wren;

    int n_cmp = 0;
    int n_err = 0;

    regfile_writeback #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .tick_alu_valid   (tick_alu_valid),
        .alu_ready        (alu_ready),
        .tick_alu_waddr   (tick_alu_waddr),
        .tick_alu_wdata   (tick_alu_wdata),
        .tick_load_valid  (tick_load_valid),
        .load_ready       (load_ready),
        .tick_load_waddr  (tick_load_waddr),
        .tick_load_word   (tick_load_word),
        .tick_load_funct3 (tick_load_funct3),
        .tick_load_offset (tick_load_offset),
        .wb_waddr         (wb_waddr),
        .wb_wdata         (wb_wdata),
        .wb_wren          (wb_wren)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic wren,
                            input logic [7:0] waddr, input logic [31:0] wdata);
        check({tag, ".wren"}, {31'h0, wb_wren}, {31'h0, wren});
        check({tag, ".waddr"}, {24'h0, wb_waddr}, {24'h0, waddr});
        check({tag, ".wdata"}, wb_wdata, wdata);
    endtask

    task automatic drive_load(input logic [7:0] waddr, input logic [31:0] word,
                              input logic [2:0] f3, input logic [1:0] off);
        tick_load_valid  = 1'b1;
        tick_load_waddr  = waddr;
        tick_load_word   = word;
        tick_load_funct3 = f3;
        tick_load_offset = off;
    endtask

    task automatic load_check(input string tag, input logic [7:0] waddr,
                              input logic [31:0] word, input logic [2:0] f3,
                              input logic [1:0] off, input logic [31:0] exp);
        drive_load(waddr, word, f3, off);
        step();
        tick_load_valid = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        check_wb(tag, 1'b1, waddr, exp);
`else
        check({tag, ".early"}, {31'h0, wb_wren}, 32'h0);
        step();
        check_wb(tag, 1'b1, waddr, exp);
`endif
        step();
    endtask

    initial begin
        reset            = 1'b1;
        tick_alu_valid   = 1'b0;
        tick_alu_waddr   = 8'h0;
        tick_alu_wdata   = 32'h0;
        tick_load_valid  = 1'b0;
        tick_load_waddr  = 8'h0;
        tick_load_word   = 32'h0;
        tick_load_funct3 = 3'h0;
        tick_load_offset = 2'h0;

        step();
        step();
        check_wb("rst", 1'b0, 8'h00, 32'h0);
        check("rst.load_ready", {31'h0, load_ready}, 32'h1);
        check("rst.alu_ready", {31'h0, alu_ready}, 32'h1);
        reset = 1'b0;
        step();
        check("post_rst.wren", {31'h0, wb_wren}, 32'h0);

        tick_alu_valid = 1'b1;
        tick_alu_waddr = 8'h23;
        tick_alu_wdata = 32'hDEADBEEF;
        step();
        tick_alu_valid = 1'b0;
        check_wb("alu", 1'b1, 8'h23, 32'hDEADBEEF);
        step();
        check("alu.pulse", {31'h0, wb_wren}, 32'h0);

        load_check("lb3",  8'h05, 32'h80FF7F01, 3'd0, 2'd3, 32'hFFFFFF80);
        load_check("lbu3", 8'h06, 32'h80FF7F01, 3'd4, 2'd3, 32'h00000080);
        load_check("lh2",  8'h07, 32'h80FF7F01, 3'd1, 2'd2, 32'hFFFF80FF);
        load_check("lhu1", 8'h08, 32'h80FF7F01, 3'd5, 2'd1, 32'h00007F01);
        load_check("lb1",  8'h09, 32'h80FF7F01, 3'd0, 2'd1, 32'h0000007F);
        load_check("lw",   8'h0A, 32'h80FF7F01, 3'd2, 2'd0, 32'h80FF7F01);

        tick_alu_valid = 1'b1;
        tick_alu_waddr = 8'h40;
        tick_alu_wdata = 32'h11111111;
        step();
        check_wb("x0", 1'b0, 8'h40, 32'h11111111);
        tick_alu_waddr = 8'h41;
        tick_alu_wdata = 32'h22222222;
        step();
        check_wb("x1", 1'b1, 8'h41, 32'h22222222);

        tick_alu_waddr = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick_alu_wdata = 32'hA0 + i;
            drive_load(8'h10 + 8'(i), 32'h1000 + i, 3'd2, 2'd0);
            check("fill.load_ready", {31'h0, load_ready}, 32'h1);
            step();
            check_wb("fill.alu", 1'b1, 8'h01, 32'hA0 + i);
        end
        tick_load_valid = 1'b0;
        check("full.load_ready", {31'h0, load_ready}, 32'h0);
        check("starve3.alu_ready", {31'h0, alu_ready}, 32'h1);
        tick_alu_wdata = 32'hB0;
        step();
        check("starve4.alu_ready", {31'h0, alu_ready}, 32'h0);
        tick_alu_wdata = 32'hB1;
        step();
        check_wb("starve.head", 1'b1, 8'h10, 32'h1000);
        check("starve.clear", {31'h0, alu_ready}, 32'h1);
        check("starve.not_full", {31'h0, load_ready}, 32'h1);
        tick_alu_valid = 1'b0;
        step();
        check_wb("drain1", 1'b1, 8'h11, 32'h1001);
        step();
        check_wb("drain2", 1'b1, 8'h12, 32'h1002);
        step();
        check_wb("drain3", 1'b1, 8'h13, 32'h1003);
        step();
        check("drain.idle", {31'h0, wb_wren}, 32'h0);

        tick_alu_valid = 1'b1;
        tick_alu_waddr = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick_alu_wdata = 32'hC0 + i;
            drive_load(8'h20 + 8'(i), 32'h2000 + i, 3'd2, 2'd0);
            step();
        end
        tick_load_valid = 1'b0;
        tick_alu_valid  = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst.wren", {31'h0, wb_wren}, 32'h0);
        check("mid_rst.load_ready", {31'h0, load_ready}, 32'h1);
        check("mid_rst.alu_ready", {31'h0, alu_ready}, 32'h1);
        step();
        check("mid_rst.hold", {31'h0, wb_wren}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stale.wren", {31'h0, wb_wren}, 32'h0);
        end
        check("stale.load_ready", {31'h0, load_ready}, 32'h1);

        load_check("lat", 8'h05, 32'h12345678, 3'd2, 2'd0, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
